// File: rtl/sign_magnitude_restore_pkg.sv
// rtl/sign_magnitude_restore_pkg.sv - shared definitions for the sign/magnitude restore block
//
// Purpose:
//   Common constants and FSM encodings used by sign_magnitude_restore and
//   its chunk negation helper.
//
// Contents:
//   WordWidth           - default datapath word width
//   SmChunkWidthDefault - default number of bits negated per cycle
//   SmMostNeg           - most-negative 32-bit two's-complement value
//   sm_state_e          - FSM state encoding (SM_IDLE / SM_CONVERT / SM_DONE)

package sign_magnitude_restore_pkg;

  localparam int WordWidth           = 32;
  localparam int SmChunkWidthDefault = 8;

  // The one operand whose magnitude does not fit a positive signed word.
  localparam logic [31:0] SmMostNeg = 32'h8000_0000;

  typedef enum logic [1:0] {
    SM_IDLE    = 2'd0,
    SM_CONVERT = 2'd1,
    SM_DONE    = 2'd2
  } sm_state_e;

endpackage

// File: rtl/sign_magnitude_chunk_negate.sv
// rtl/sign_magnitude_chunk_negate.sv - one chunk of a chunk-serial two's-complement negation
//
// Purpose:
//   Combinational slice of a ripple negation. With i_invert=1 it computes
//   ~i_chunk + i_carry and reports the carry-out; with i_invert=0 the chunk
//   passes through unchanged and no carry is generated.
//
// Ports:
//   i_chunk  in  CHUNK_WIDTH  chunk of the working word
//   i_invert in  1            1 = negate this chunk (operand is negative)
//   i_carry  in  1            carry from the previous (lower) chunk
//   o_chunk  out CHUNK_WIDTH  resulting chunk
//   o_carry  out 1            carry into the next (higher) chunk

module sign_magnitude_chunk_negate
  import sign_magnitude_restore_pkg::*;
#(
  parameter int CHUNK_WIDTH = SmChunkWidthDefault
) (
  input  logic [CHUNK_WIDTH-1:0] i_chunk,
  input  logic                   i_invert,
  input  logic                   i_carry,
  output logic [CHUNK_WIDTH-1:0] o_chunk,
  output logic                   o_carry
);

  logic [CHUNK_WIDTH-1:0] w_operand;
  logic                   w_carry_in;
  logic [CHUNK_WIDTH:0]   w_sum;

  // The carry is only meaningful while negating; masking it here keeps a
  // positive operand bit-exact even if a stale carry were presented.
  assign w_operand  = i_invert ? ~i_chunk : i_chunk;
  assign w_carry_in = i_invert & i_carry;
  assign w_sum      = {1'b0, w_operand} + {{CHUNK_WIDTH{1'b0}}, w_carry_in};

  assign o_chunk = w_sum[CHUNK_WIDTH-1:0];
  assign o_carry = w_sum[CHUNK_WIDTH];

endmodule

// File: rtl/sign_magnitude_restore.sv
// rtl/sign_magnitude_restore.sv - two's-complement word to sign plus unsigned magnitude, chunk-serial
//
// Purpose:
//   Converts a two's-complement operand into a sign bit and an unsigned
//   magnitude for the multiply/divide path. Negation is performed one chunk
//   per cycle, LSB chunk first, with a registered carry between chunks so
//   only a CHUNK_WIDTH adder sits in the path.
//
// Build option:
//   SIGN_MAG_FAST_POSITIVE_EN - when defined, non-negative operands skip the
//   CONVERT phase and the result is valid the cycle after accept. When not
//   defined, every operand takes NUM_CHUNKS cycles (fixed latency).
//
// Ports:
//   clock          in  1           system clock, rising edge
//   reset          in  1           synchronous, active-high
//   in_Valid       in  1           in_Operand is valid this cycle
//   in_Operand     in  WORD_WIDTH  two's-complement input
//   out_Accept     out 1           IDLE; operand is latched this edge if in_Valid=1
//   out_Valid      out 1           result is valid
//   out_Sign       out 1           1 = operand was negative
//   out_Magnitude  out WORD_WIDTH  unsigned |operand| (modulo 2^WORD_WIDTH)
//   out_Overflow   out 1           operand was the most-negative value
//   in_Taken       in  1           consumer takes the result (only while out_Valid=1)

module sign_magnitude_restore
  import sign_magnitude_restore_pkg::*;
#(
  parameter int WORD_WIDTH  = WordWidth,
  parameter int CHUNK_WIDTH = SmChunkWidthDefault
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_Valid,
  input  logic [WORD_WIDTH-1:0] in_Operand,
  output logic                  out_Accept,
  output logic                  out_Valid,
  output logic                  out_Sign,
  output logic [WORD_WIDTH-1:0] out_Magnitude,
  output logic                  out_Overflow,
  input  logic                  in_Taken
);

  // WORD_WIDTH is expected to be a whole multiple of CHUNK_WIDTH.
  localparam int NUM_CHUNKS = WORD_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [WORD_WIDTH-1:0] MOST_NEG = {1'b1, {(WORD_WIDTH-1){1'b0}}};

  sm_state_e r_state;
  sm_state_e w_next_state;

  logic [WORD_WIDTH-1:0]  r_word;
  logic                   r_sign;
  logic                   r_carry;
  logic [IDX_W-1:0]       r_idx;

  logic [CHUNK_WIDTH-1:0] w_chunk_in;
  logic [CHUNK_WIDTH-1:0] w_chunk_out;
  logic                   w_carry_out;
  logic                   w_accept_fire;
  logic                   w_last_chunk;

  assign w_accept_fire = (r_state == SM_IDLE) && in_Valid;
  assign w_last_chunk  = (r_idx == LAST_IDX);
  assign w_chunk_in    = r_word[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];

  sign_magnitude_chunk_negate #(
    .CHUNK_WIDTH (CHUNK_WIDTH)
  ) u_chunk_negate (
    .i_chunk  (w_chunk_in),
    .i_invert (r_sign),
    .i_carry  (r_carry),
    .o_chunk  (w_chunk_out),
    .o_carry  (w_carry_out)
  );

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= SM_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    out_Accept   = 1'b0;
    out_Valid    = 1'b0;
    out_Overflow = 1'b0;

    unique case (r_state)
      SM_IDLE: begin
        out_Accept = 1'b1;
        if (in_Valid) begin
`ifdef SIGN_MAG_FAST_POSITIVE_EN
          // A non-negative operand is already its own magnitude.
          w_next_state = in_Operand[WORD_WIDTH-1] ? SM_CONVERT : SM_DONE;
`else
          w_next_state = SM_CONVERT;
`endif
        end
      end

      SM_CONVERT: begin
        if (w_last_chunk) begin
          w_next_state = SM_DONE;
        end
      end

      SM_DONE: begin
        out_Valid = 1'b1;
        // Only the most-negative operand leaves sign=1 with this bit pattern.
        out_Overflow = r_sign && (r_word == MOST_NEG);
        if (in_Taken) begin
          w_next_state = SM_IDLE;
        end
      end

      default: begin
        w_next_state = SM_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Working register, chunk index and registered carry
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word  <= '0;
      r_sign  <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept_fire) begin
      // The +1 of the negation enters as the initial carry into chunk 0.
      r_word  <= in_Operand;
      r_sign  <= in_Operand[WORD_WIDTH-1];
      r_carry <= 1'b1;
      r_idx   <= '0;
    end else if (r_state == SM_CONVERT) begin
      r_word[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH] <= w_chunk_out;
      r_carry <= w_carry_out;
      r_idx   <= w_last_chunk ? '0 : r_idx + 1'b1;
    end
  end

  assign out_Sign      = r_sign;
  assign out_Magnitude = r_word;

endmodule

// File: tb/tb_sign_magnitude_restore.sv
// tb/tb_sign_magnitude_restore.sv - self-checking bench for sign_magnitude_restore

module tb_sign_magnitude_restore;
  import sign_magnitude_restore_pkg::*;

  localparam int W  = 32;
  localparam int NC = 4;

  typedef struct packed {
    logic          sign;
    logic [W-1:0]  mag;
    logic          ovf;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_Valid;
  logic [W-1:0] in_Operand;
  logic         out_Accept;
  logic         out_Valid;
  logic         out_Sign;
  logic [W-1:0] out_Magnitude;
  logic         out_Overflow;
  logic         in_Taken;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  sign_magnitude_restore dut (
    .clock         (clock),
    .reset         (reset),
    .in_Valid      (in_Valid),
    .in_Operand    (in_Operand),
    .out_Accept    (out_Accept),
    .out_Valid     (out_Valid),
    .out_Sign      (out_Sign),
    .out_Magnitude (out_Magnitude),
    .out_Overflow  (out_Overflow),
    .in_Taken      (in_Taken)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] op);
    exp_t e;
    e.sign = op[W-1];
    e.mag  = op[W-1] ? (32'd0 - op) : op;
    e.ovf  = (op == SmMostNeg);
    return e;
  endfunction

  function automatic int exp_latency(input logic [W-1:0] op);
`ifdef SIGN_MAG_FAST_POSITIVE_EN
    return op[W-1] ? NC : 0;
`else
    return (op == op) ? NC : NC;
`endif
  endfunction

  // Drive one operand from a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [W-1:0] op);
    int k = 0;
    while (!out_Accept && k < 50) begin
      @(posedge clock);
      @(negedge clock);
      k++;
    end
    check("accept_ready", 32'(out_Accept), 32'd1);
    in_Valid   = 1'b1;
    in_Operand = op;
    sb_q.push_back(model(op));
    @(posedge clock);
    @(negedge clock);
    in_Valid = 1'b0;
  endtask

  // Wait (bounded) for out_Valid, checking latency and the popped expectation.
  task automatic wait_result(input string tag, input bit scramble, input int exp_lat);
    int   lat = 0;
    exp_t e;
    while (!out_Valid && lat < 50) begin
      if (scramble) in_Operand = $urandom;
      @(posedge clock);
      @(negedge clock);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (sb_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_valid"}, 32'(out_Valid), 32'd1);
      check({tag, "_sign"}, 32'(out_Sign), 32'(e.sign));
      check({tag, "_mag"}, out_Magnitude, e.mag);
      check({tag, "_ovf"}, 32'(out_Overflow), 32'(e.ovf));
      check({tag, "_no_accept"}, 32'(out_Accept), 32'd0);
    end
  endtask

  task automatic take(input string tag);
    in_Taken = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_Taken = 1'b0;
    check({tag, "_taken_valid"}, 32'(out_Valid), 32'd0);
    check({tag, "_taken_accept"}, 32'(out_Accept), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] op);
    send(op);
    wait_result(tag, 1'b0, exp_latency(op));
    take(tag);
  endtask

  initial begin
    logic [W-1:0] op;
    exp_t         held;

    reset      = 1'b1;
    in_Valid   = 1'b0;
    in_Operand = '0;
    in_Taken   = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rst_accept", 32'(out_Accept), 32'd1);
    check("rst_valid", 32'(out_Valid), 32'd0);
    check("rst_sign", 32'(out_Sign), 32'd0);
    check("rst_mag", out_Magnitude, 32'd0);
    check("rst_ovf", 32'(out_Overflow), 32'd0);

    // Positive operand with in_Taken held high throughout.
    in_Taken = 1'b1;
    send(32'h0907_9E70);
    wait_result("pos", 1'b0, exp_latency(32'h0907_9E70));
    @(posedge clock);
    @(negedge clock);
    in_Taken = 1'b0;
    check("pos_taken_valid", 32'(out_Valid), 32'd0);
    check("pos_taken_accept", 32'(out_Accept), 32'd1);

    run_op("neg", 32'hF6F8_6190);
    run_op("ripple", 32'hFFFF_FF00);
    run_op("minus1", 32'hFFFF_FFFF);
    run_op("mostneg", 32'h8000_0000);
    run_op("zero", 32'h0000_0000);
    run_op("maxpos", 32'h7FFF_FFFF);

    // Backpressure: result held for 10 cycles while a new operand is offered.
    send(32'hFFFE_0001);
    held = model(32'hFFFE_0001);
    wait_result("bp", 1'b0, exp_latency(32'hFFFE_0001));
    for (int i = 0; i < 10; i++) begin
      in_Valid   = 1'b1;
      in_Operand = $urandom;
      @(posedge clock);
      @(negedge clock);
      check("bp_hold_valid", 32'(out_Valid), 32'd1);
      check("bp_hold_mag", out_Magnitude, held.mag);
      check("bp_hold_sign", 32'(out_Sign), 32'(held.sign));
      check("bp_hold_accept", 32'(out_Accept), 32'd0);
    end
    in_Valid = 1'b0;
    take("bp");
    run_op("bp_next", 32'hDEAD_BEEF);

    // Operand changes every cycle after accept.
    send(32'hA5A5_0F0F);
    wait_result("scramble", 1'b1, exp_latency(32'hA5A5_0F0F));
    take("scramble");

    // Reset while converting chunk index 2, then a fresh conversion.
    send(32'hFFFF_00FF);
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    void'(sb_q.pop_front());
    check("abort_valid", 32'(out_Valid), 32'd0);
    check("abort_accept", 32'(out_Accept), 32'd1);
    check("abort_mag", out_Magnitude, 32'd0);
    run_op("after_abort", 32'hFFFF_00FF);

    for (int i = 0; i < 4; i++) begin
      op = $urandom;
      run_op("random", op);
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
